alu_unit_pipelined: RTL

//  Parametrised, back-pressurable successor to the single-cycle ALU execution unit.

---
 rtl/alu_unit_pipelined_pkg.sv | 18 +
 rtl/alu_unit_pipelined_if.sv | 41 ++++
 rtl/alu_wb_fifo.sv | 51 +++++
 rtl/alu_unit_pipelined.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_unit_pipelined_pkg.sv
// Shared ALU type definitions: operation and logic-op selectors driven by decode.
package alu_unit_pipelined_pkg;

    typedef enum logic [1:0] {
        ALU_CONSTANT = 2'd0,
        ALU_ADD_SUB  = 2'd1,
        ALU_SLT      = 2'd2,
        ALU_SHIFT    = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        ALU_LOGIC_ADD = 2'd0,
        ALU_LOGIC_XOR = 2'd1,
        ALU_LOGIC_OR  = 2'd2,
        ALU_LOGIC_AND = 2'd3
    } alu_logic_op_t;

endpackage

// File: rtl/alu_unit_pipelined_if.sv
// Issue and writeback signals of the pipelined ALU unit.
// The master side is issue/writeback logic; the slave side is the ALU unit itself.
interface alu_unit_pipelined_if
    import alu_unit_pipelined_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ID_W = 3
);
    localparam int SHAMT_W = $clog2(XLEN);

    logic                issue_new_request;
    logic [ID_W-1:0]     issue_id;
    logic                issue_ready;
    logic [XLEN:0]       in1;
    logic [XLEN:0]       in2;
    logic                subtract;
    alu_logic_op_t       logic_op;
    alu_op_t             alu_op;
    logic [XLEN-1:0]     constant_adder;
    logic [XLEN-1:0]     shifter_in;
    logic [SHAMT_W-1:0]  shift_amount;
    logic                arith;
    logic                lshift;
    logic                wb_done;
    logic                wb_ack;
    logic [ID_W-1:0]     wb_id;
    logic [XLEN-1:0]     wb_rd;

    modport master (
        output issue_new_request, issue_id, in1, in2, subtract, logic_op, alu_op,
               constant_adder, shifter_in, shift_amount, arith, lshift, wb_ack,
        input  issue_ready, wb_done, wb_id, wb_rd
    );

    modport slave (
        input  issue_new_request, issue_id, in1, in2, subtract, logic_op, alu_op,
               constant_adder, shifter_in, shift_amount, arith, lshift, wb_ack,
        output issue_ready, wb_done, wb_id, wb_rd
    );

endinterface

// File: rtl/alu_wb_fifo.sv
// In-order writeback FIFO with registered storage and wrap-bit pointers.
// Read and write in the same cycle are allowed even when full.
module alu_wb_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] storage [DEPTH];

    // NOTE: sequential state is updated with non-blocking (<=) assignments only, so every
    // flop samples pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: storage is reset on purpose: the head is visible on wb_id/wb_rd even while empty,
    // and those outputs must read zero out of reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (wr_en) begin
            storage[wr_ptr[PTR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data = storage[rd_ptr[PTR_W-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst) !(rd_en && empty));

endmodule

// File: rtl/alu_unit_pipelined.sv
// Back-pressurable ALU execution unit: combinational execute, optional output register,
// and a credit-gated writeback FIFO so that no result is ever dropped.
module alu_unit_pipelined
    import alu_unit_pipelined_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ID_W       = 3,
    parameter int OUTPUT_REG = 1,
    parameter int FIFO_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst,
    alu_unit_pipelined_if.slave alu
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = XLEN + ID_W;

    logic                accept;
    logic                pop;
    logic                ready;
    logic [CNT_W-1:0]    credit_count;

    logic [XLEN:0]       add_a;
    logic [XLEN:0]       add_b;
    logic [XLEN:0]       add_res;

    logic [SHAMT_W-1:0]  shamt;
    logic                shift_fill;
    logic [XLEN-1:0]     shift_src;
    logic [XLEN-1:0]     shift_stage [SHAMT_W+1];
    logic [XLEN-1:0]     shift_right;
    logic [XLEN-1:0]     shift_out;

    logic [XLEN-1:0]     result;
    logic [ENTRY_W-1:0]  issue_entry;
    logic                stage_valid;
    logic [ENTRY_W-1:0]  stage_data;

    logic [ENTRY_W-1:0]  head_data;
    logic                fifo_empty;
    logic                fifo_full;

    // Credits cover both the output stage and the FIFO, so issue never outruns storage.
    assign ready           = (credit_count < CNT_W'(FIFO_DEPTH));
    assign alu.issue_ready = ready;
    assign accept          = alu.issue_new_request & ready;
    assign pop             = ~fifo_empty & alu.wb_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_count <= '0;
        end else begin
            unique case ({accept, pop})
                2'b10:   credit_count <= credit_count + CNT_W'(1);
                2'b01:   credit_count <= credit_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Logic ops ride through the adder with a zero second operand.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned,
        // which would otherwise infer a latch.
        add_a = alu.in1;
        add_b = alu.in2 ^ {(XLEN+1){alu.subtract}};
        unique case (alu.logic_op)
            ALU_LOGIC_XOR: begin add_a = alu.in1 ^ alu.in2; add_b = '0; end
            ALU_LOGIC_OR:  begin add_a = alu.in1 | alu.in2; add_b = '0; end
            ALU_LOGIC_AND: begin add_a = alu.in1 & alu.in2; add_b = '0; end
            default:       ;
        endcase
    end

    assign add_res = add_a + add_b + {{XLEN{1'b0}}, alu.subtract};

    // Left shifts reuse the right shifter by bit-reversing operand and result.
    assign shamt          = alu.shift_amount;
    assign shift_fill     = alu.arith & ~alu.lshift & alu.shifter_in[XLEN-1];
    assign shift_src      = alu.lshift ? {<<{alu.shifter_in}} : alu.shifter_in;
    assign shift_stage[0] = shift_src;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_shift
        localparam int STEP = 1 << k;
        assign shift_stage[k+1] = shamt[k] ?
            {{STEP{shift_fill}}, shift_stage[k][XLEN-1:STEP]} : shift_stage[k];
    end

    assign shift_right = shift_stage[SHAMT_W];
    assign shift_out   = alu.lshift ? {<<{shift_right}} : shift_right;

    always_comb begin
        result = add_res[XLEN-1:0];
        unique case (alu.alu_op)
            ALU_CONSTANT: result = alu.constant_adder;
            ALU_SLT:      result = {{(XLEN-1){1'b0}}, add_res[XLEN]};
            ALU_SHIFT:    result = shift_out;
            default:      ;
        endcase
    end

    assign issue_entry = {alu.issue_id, result};

    if (OUTPUT_REG != 0) begin : g_out_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_valid <= 1'b0;
                stage_data  <= '0;
            end else begin
                stage_valid <= accept;
                if (accept) stage_data <= issue_entry;
            end
        end
    end else begin : g_no_out_reg
        assign stage_valid = accept;
        assign stage_data  = issue_entry;
    end

    alu_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) wb_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (stage_valid),
        .wr_data (stage_data),
        .rd_en   (pop),
        .rd_data (head_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign alu.wb_done = ~fifo_empty;
    assign alu.wb_id   = head_data[ENTRY_W-1:XLEN];
    assign alu.wb_rd   = head_data[XLEN-1:0];

    a_no_write_when_full: assert property (@(posedge clk) disable iff (rst)
        !(stage_valid && fifo_full && !pop));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        credit_count <= CNT_W'(FIFO_DEPTH));

endmodule
